// File: rtl/iir_biquad_cascade.sv
// Cascade of NSEC direct-form-I biquads sharing one multiplier-accumulator.
// Each sample takes one accept cycle, 5*NSEC MAC cycles and one output cycle.
module iir_biquad_cascade #(
   parameter int WIDTH     = 16,
   parameter int CW        = 16,
   parameter int COEF_FRAC = 14,
   parameter int NSEC      = 2
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic signed [WIDTH-1:0]   x_in_i,
   input  logic                      bypass_i,
   input  logic                      coef_we_i,
   input  logic [$clog2(5*NSEC)-1:0] coef_addr_i,
   input  logic signed [CW-1:0]      coef_data_i,
   output logic                      coef_err_o,
   output logic                      out_valid_o,
   output logic signed [WIDTH-1:0]   y_out_o,
   output logic signed [WIDTH-1:0]   ntf_out_o,
   output logic                      sat_o
);
   localparam int AW    = $clog2(5*NSEC);
   localparam int NCOEF = 5*NSEC;
   localparam int PW    = WIDTH + CW;
   localparam int ACCW  = PW + 3;
   localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
   localparam logic signed [ACCW-1:0] RND      = ACCW'(1) << (COEF_FRAC-1);
   localparam logic signed [CW-1:0]   COEF_ONE = CW'(1) << COEF_FRAC;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

   state_t                   r_state;
   logic [SW-1:0]            r_sec;
   logic [2:0]               r_tap;
   logic signed [ACCW-1:0]   r_acc;
   logic signed [WIDTH-1:0]  r_x, r_xc;
   logic                     r_bypass, r_sat;
   logic signed [CW-1:0]     r_coef [NCOEF];
   logic signed [WIDTH-1:0]  r_x1 [NSEC];
   logic signed [WIDTH-1:0]  r_x2 [NSEC];
   logic signed [WIDTH-1:0]  r_y1 [NSEC];
   logic signed [WIDTH-1:0]  r_y2 [NSEC];
   logic                     r_out_valid, r_coef_err, r_sat_out;
   logic signed [WIDTH-1:0]  r_y_out, r_ntf_out;

   logic [AW-1:0]            w_cidx;
   logic signed [CW-1:0]     w_coef;
   logic signed [WIDTH-1:0]  w_op;
   logic signed [PW-1:0]     w_prod;
   logic signed [ACCW-1:0]   w_prod_ext, w_acc_base, w_acc_next, w_rnd, w_r;
   logic [ACCW-WIDTH:0]      w_hi;
   logic                     w_clip;
   logic signed [WIDTH-1:0]  w_ys, w_y_final, w_ntf;
   logic signed [WIDTH:0]    w_diff;

   assign w_cidx = AW'(r_sec * 5 + r_tap);
   assign w_coef = r_coef[w_cidx];

   always_comb begin
      w_op = r_xc;
      case (r_tap)
         3'd0:    w_op = r_xc;
         3'd1:    w_op = r_x1[r_sec];
         3'd2:    w_op = r_x2[r_sec];
         3'd3:    w_op = r_y1[r_sec];
         default: w_op = r_y2[r_sec];
      endcase
   end

   assign w_prod     = $signed({{CW{w_op[WIDTH-1]}}, w_op}) * $signed({{WIDTH{w_coef[CW-1]}}, w_coef});
   assign w_prod_ext = {{3{w_prod[PW-1]}}, w_prod};
   assign w_acc_base = (r_tap == 3'd0) ? '0 : r_acc;
   // Feedback taps a1/a2 are stored with their natural sign and subtracted here.
   assign w_acc_next = (r_tap >= 3'd3) ? (w_acc_base - w_prod_ext) : (w_acc_base + w_prod_ext);
   assign w_rnd      = w_acc_next + RND;
   assign w_r        = w_rnd >>> COEF_FRAC;
   assign w_hi       = w_r[ACCW-1:WIDTH-1];
   assign w_clip     = !((&w_hi) || !(|w_hi));
   assign w_ys       = !w_clip ? w_r[WIDTH-1:0] :
                       (w_r[ACCW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});

   assign w_y_final  = r_bypass ? r_x : r_xc;
   assign w_diff     = {r_x[WIDTH-1], r_x} - {w_y_final[WIDTH-1], w_y_final};
   assign w_ntf      = (w_diff[WIDTH] == w_diff[WIDTH-1]) ? w_diff[WIDTH-1:0] :
                       (w_diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_state     <= S_IDLE;
         r_sec       <= '0;
         r_tap       <= '0;
         r_acc       <= '0;
         r_x         <= '0;
         r_xc        <= '0;
         r_bypass    <= 1'b0;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
         r_coef_err  <= 1'b0;
         r_sat_out   <= 1'b0;
         r_y_out     <= '0;
         r_ntf_out   <= '0;
         for (int i = 0; i < NCOEF; i++)
            r_coef[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
         for (int i = 0; i < NSEC; i++) begin
            r_x1[i] <= '0;
            r_x2[i] <= '0;
            r_y1[i] <= '0;
            r_y2[i] <= '0;
         end
      end else begin
         r_out_valid <= 1'b0;
         r_coef_err  <= 1'b0;
         // Coefficients may only change between samples so a sample never sees a mixed set.
         if (coef_we_i) begin
            if (r_state == S_IDLE && coef_addr_i < AW'(NCOEF))
               r_coef[coef_addr_i] <= coef_data_i;
            else
               r_coef_err <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (in_valid_i) begin
                  r_x      <= x_in_i;
                  r_xc     <= x_in_i;
                  r_bypass <= bypass_i;
                  r_sat    <= 1'b0;
                  r_sec    <= '0;
                  r_tap    <= '0;
                  r_state  <= S_MAC;
               end
            end
            S_MAC: begin
               r_acc <= w_acc_next;
               if (r_tap == 3'd4) begin
                  if (!r_bypass) begin
                     r_x2[r_sec] <= r_x1[r_sec];
                     r_x1[r_sec] <= r_xc;
                     r_y2[r_sec] <= r_y1[r_sec];
                     r_y1[r_sec] <= w_ys;
                     r_xc        <= w_ys;
                     if (w_clip)
                        r_sat <= 1'b1;
                  end
                  r_tap <= '0;
                  if (r_sec == SW'(NSEC-1))
                     r_state <= S_DONE;
                  else
                     r_sec <= r_sec + 1'b1;
               end else begin
                  r_tap <= r_tap + 3'd1;
               end
            end
            S_DONE: begin
               r_out_valid <= 1'b1;
               r_y_out     <= w_y_final;
               r_ntf_out   <= w_ntf;
               r_sat_out   <= r_sat & ~r_bypass;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o  = (r_state == S_IDLE);
   assign coef_err_o  = r_coef_err;
   assign out_valid_o = r_out_valid;
   assign y_out_o     = r_y_out;
   assign ntf_out_o   = r_ntf_out;
   assign sat_o       = r_sat_out;
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed bench for iir_biquad_cascade: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them whenever out_valid_o pulses.
module tb_iir_biquad_cascade;
   localparam int WIDTH = 16;
   localparam int CW    = 16;
   localparam int NSEC  = 2;
   localparam int AW    = $clog2(5*NSEC);
   localparam int LAT   = 5*NSEC + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     reset_i = 1'b0;
   logic                     in_valid_i = 1'b0;
   logic                     in_ready_o;
   logic signed [WIDTH-1:0]  x_in_i = '0;
   logic                     bypass_i = 1'b0;
   logic                     coef_we_i = 1'b0;
   logic [AW-1:0]            coef_addr_i = '0;
   logic signed [CW-1:0]     coef_data_i = '0;
   logic                     coef_err_o;
   logic                     out_valid_o;
   logic signed [WIDTH-1:0]  y_out_o;
   logic signed [WIDTH-1:0]  ntf_out_o;
   logic                     sat_o;

   iir_biquad_cascade #(.WIDTH(WIDTH), .CW(CW), .COEF_FRAC(14), .NSEC(NSEC)) dut (
      .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .x_in_i(x_in_i), .bypass_i(bypass_i), .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i),
      .coef_data_i(coef_data_i), .coef_err_o(coef_err_o), .out_valid_o(out_valid_o),
      .y_out_o(y_out_o), .ntf_out_o(ntf_out_o), .sat_o(sat_o)
   );

   typedef struct {
      logic signed [WIDTH-1:0] y;
      logic signed [WIDTH-1:0] ntf;
      logic                    sat;
      int                      cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   n_out = 0;
   int   n_exp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (out_valid_o === 1'b1) begin
         exp_t e;
         n_out++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: actual y=%0d required no output", y_out_o);
         end else begin
            e = q.pop_front();
            $display("txn %0d: y=%0d ntf=%0d sat=%0d (exp y=%0d ntf=%0d sat=%0d) cyc=%0d",
                     n_out, y_out_o, ntf_out_o, sat_o, e.y, e.ntf, e.sat, cyc);
            chk("y_out", y_out_o, e.y);
            chk("ntf_out", ntf_out_o, e.ntf);
            chk("sat", sat_o, e.sat);
            chk("latency_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic send(input logic signed [WIDTH-1:0] x, input logic byp,
                       input logic signed [WIDTH-1:0] ey, input logic signed [WIDTH-1:0] en,
                       input logic es);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (in_ready_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: actual in_ready=%0b required 1 within 100 cycles", in_ready_o);
      end
      x_in_i = x;
      bypass_i = byp;
      in_valid_i = 1'b1;
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      bypass_i = 1'b0;
      e.y = ey;
      e.ntf = en;
      e.sat = es;
      e.cyc = cyc + LAT;
      q.push_back(e);
      n_exp++;
      chk("ready_low_busy", in_ready_o, 0);
   endtask

   task automatic wr(input int addr, input logic signed [CW-1:0] d, input logic eerr);
      @(negedge clk);
      coef_we_i = 1'b1;
      coef_addr_i = AW'(addr);
      coef_data_i = d;
      @(posedge clk);
      #1;
      coef_we_i = 1'b0;
      chk("coef_err", coef_err_o, eerr);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: actual pending=%0d required 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic rst();
      @(negedge clk);
      reset_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_i = 1'b1;
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_y", y_out_o, 0);
      chk("rst_ntf", ntf_out_o, 0);
      chk("rst_sat", sat_o, 0);
      chk("rst_coef_err", coef_err_o, 0);
      chk("rst_in_ready", in_ready_o, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: actual running required finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst();
      // T1 default coefficients pass the sample through
      send(16'sd30, 1'b0, 16'sd30, 16'sd0, 1'b0);
      drain();
      // T2 sec0 b0 = 0.5
      wr(0, 16'sd8192, 1'b0);
      send(16'sd1000, 1'b0, 16'sd500, 16'sd500, 1'b0);
      send(16'sd20, 1'b0, 16'sd10, 16'sd10, 1'b0);
      drain();
      // T3 sec0 a1 = -1.0 -> running sum
      rst();
      wr(3, -16'sd16384, 1'b0);
      send(16'sd100, 1'b0, 16'sd100, 16'sd0, 1'b0);
      send(16'sd100, 1'b0, 16'sd200, -16'sd100, 1'b0);
      send(16'sd100, 1'b0, 16'sd300, -16'sd200, 1'b0);
      drain();
      // T4 saturation at both rails
      rst();
      wr(0, 16'sd32767, 1'b0);
      wr(5, 16'sd32767, 1'b0);
      send(16'sd32767, 1'b0, 16'sd32767, 16'sd0, 1'b1);
      send(-16'sd32768, 1'b0, -16'sd32768, 16'sd0, 1'b1);
      drain();
      // T5 dropped writes, then bypass leaves history intact
      rst();
      send(16'sd40, 1'b0, 16'sd40, 16'sd0, 1'b0);
      wr(0, 16'sd8192, 1'b1);
      drain();
      wr(5*NSEC, 16'sd16384, 1'b1);
      send(16'sd50, 1'b0, 16'sd50, 16'sd0, 1'b0);
      drain();
      wr(1, 16'sd16384, 1'b0);
      send(16'sd4500, 1'b1, 16'sd4500, 16'sd0, 1'b0);
      drain();
      send(16'sd10, 1'b0, 16'sd60, -16'sd50, 1'b0);
      drain();
      // T6 reset mid-MAC aborts the sample
      send(16'sd700, 1'b0, 16'sd700, 16'sd0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_i = 1'b0;
      q.delete();
      n_exp--;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_i = 1'b1;
      repeat (20) @(negedge clk);
      send(16'sd1500, 1'b0, 16'sd1500, 16'sd0, 1'b0);
      drain();
      chk("output_count", n_out, n_exp);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
